if_id_queue: RTL and testbench

//  Decoupling queue between the instruction-fetch stage and instruction decode.

---
 rtl/mips_pkg.sv | 10 +
 rtl/if_id_queue.sv | 98 +++++++++
 tb/tb_if_id_queue.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: datapath widths and the canonical NOP encoding.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;

  // sll $0,$0,0
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling queue: in-order {instr, pc} buffer with PC+4 precomputed
// for decode and a flush that drops every held entry.
module if_id_queue
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = INSTR_W,
  parameter int unsigned ADDR_W = PC_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_instr,
  input  logic [ADDR_W-1:0]          in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [ADDR_W-1:0]          out_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              push, pop;

  assign in_ready  = (count_q != CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observable through count/rd_ptr.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr_q] <= in_instr;
      pc_q[wr_ptr_q]    <= in_pc;
    end
  end

  always_comb begin
    out_instr    = DATA_W'(NOP_INSTR);
    out_pc       = '0;
    out_pc_plus4 = '0;
    if (out_valid) begin
      out_instr    = instr_q[rd_ptr_q];
      out_pc       = pc_q[rd_ptr_q];
      out_pc_plus4 = pc_q[rd_ptr_q] + ADDR_W'(4);
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CntW'(DEPTH));
  a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (count_q != CntW'(DEPTH)));
  a_no_pop_empty : assert property (@(posedge clk) disable iff (!rst_n)
    pop |-> (count_q != '0));

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reset, fill, streaming, full+pop, flush, PC wrap and
// asynchronous reset.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [1:0]  count;

  int total = 0;
  int bad   = 0;

  if_id_queue #(.DEPTH(2), .DATA_W(32), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_pc_plus4 (out_pc_plus4),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and let outputs settle before checking.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;

    // Reset
    step(); step();
    check("rst_count", 64'(count), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_out_instr", 64'(out_instr), 0);
    check("rst_out_pc", 64'(out_pc), 0);
    check("rst_out_pc4", 64'(out_pc_plus4), 0);
    rst_n = 1'b1;
    step();

    // Fill
    in_valid = 1'b1; in_instr = 32'h2002_0005; in_pc = 32'h0;
    step();
    check("fill1_count", 64'(count), 1);
    check("fill1_instr", 64'(out_instr), 64'h2002_0005);
    in_instr = 32'h2003_0007; in_pc = 32'h4;
    step();
    check("fill2_count", 64'(count), 2);
    check("fill2_in_ready", 64'(in_ready), 0);
    in_instr = 32'h0043_2020; in_pc = 32'h8;
    step();
    check("fill3_count", 64'(count), 2);
    check("fill3_instr", 64'(out_instr), 64'h2002_0005);
    check("fill3_pc4", 64'(out_pc_plus4), 64'h4);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("drain1_count", 64'(count), 1);
    check("drain1_instr", 64'(out_instr), 64'h2003_0007);
    step();
    check("drain2_valid", 64'(out_valid), 0);
    check("drain2_instr", 64'(out_instr), 0);
    out_ready = 1'b0;

    // Stream: count holds at 1, head is always the entry pushed at the last edge
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_pc    = 32'(4 * i);
      in_instr = 32'h1000_0000 + 32'(i);
      step();
      check("stream_count", 64'(count), 1);
      check("stream_pc", 64'(out_pc), 64'(4 * i));
      check("stream_instr", 64'(out_instr), 64'h1000_0000 + 64'(i));
    end
    in_valid = 1'b0;
    step();
    check("stream_drain", 64'(count), 0);
    out_ready = 1'b0;

    // Full + pop
    in_valid = 1'b1; in_instr = 32'hA; in_pc = 32'h100;
    step();
    in_instr = 32'hB; in_pc = 32'h104;
    step();
    check("full_count", 64'(count), 2);
    in_instr = 32'hC; in_pc = 32'h108; out_ready = 1'b1;
    step();
    check("fullpop_count", 64'(count), 1);
    check("fullpop_in_ready", 64'(in_ready), 1);
    check("fullpop_pc", 64'(out_pc), 64'h104);
    out_ready = 1'b0;
    step();
    check("refill_count", 64'(count), 2);
    check("refill_in_ready", 64'(in_ready), 0);
    check("refill_head", 64'(out_pc), 64'h104);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("refill_next", 64'(out_pc), 64'h108);
    check("refill_next_instr", 64'(out_instr), 64'hC);
    out_ready = 1'b0;

    // Flush with concurrent push and pop
    in_valid = 1'b1; in_instr = 32'hD; in_pc = 32'h10C;
    step();
    check("preflush_count", 64'(count), 2);
    flush = 1'b1; in_instr = 32'hDEAD_BEEF; in_pc = 32'h200; out_ready = 1'b1;
    step();
    check("flush_count", 64'(count), 0);
    check("flush_valid", 64'(out_valid), 0);
    check("flush_in_ready", 64'(in_ready), 1);
    check("flush_instr", 64'(out_instr), 0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    check("postflush_count", 64'(count), 0);
    in_valid = 1'b1; in_instr = 32'h1234_5678; in_pc = 32'h300;
    step();
    check("postflush_pc", 64'(out_pc), 64'h300);
    check("postflush_instr", 64'(out_instr), 64'h1234_5678);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("postflush_drain", 64'(count), 0);
    out_ready = 1'b0;

    // PC wrap
    in_valid = 1'b1; in_instr = 32'h0800_0000; in_pc = 32'hFFFF_FFFC;
    step();
    in_valid = 1'b0;
    check("wrap_pc", 64'(out_pc), 64'hFFFF_FFFC);
    check("wrap_pc4", 64'(out_pc_plus4), 0);
    check("wrap_count", 64'(count), 1);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 0);
    check("arst_count", 64'(count), 0);
    check("arst_in_ready", 64'(in_ready), 1);
    step();
    rst_n = 1'b1;
    step();
    check("post_arst_valid", 64'(out_valid), 0);
    check("post_arst_instr", 64'(out_instr), 0);
    in_valid = 1'b1; in_instr = 32'h2222_0000; in_pc = 32'h400;
    step();
    in_valid = 1'b0;
    check("post_arst_pc", 64'(out_pc), 64'h400);
    check("post_arst_pc4", 64'(out_pc_plus4), 64'h404);
    check("post_arst_count", 64'(count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
